// File: rtl/arb_mux_pkg.sv
// Shared types for the arb_mux slice: lock FSM encoding and index-width helper.
package arb_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
)(
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    localparam int JW = IW + 1;

    logic [JW-1:0] j;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = '0;
        // Walk farthest-first so the slot nearest ptr overrides the rest.
        for (int k = N - 1; k >= 0; k--) begin
            j = {1'b0, ptr} + JW'(k);
            if (j >= JW'(N)) j = j - JW'(N);
            if (req[j[IW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-to-1 arbitrating mux with one output register stage.
// Define ARB_MUX_LOCK_EN to hold ownership of a channel until its in_last beat.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int N     = 8,
    localparam int IW    = idx_w(N)
)(
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_last,
    input  logic             sel_mode,
    input  logic [IW-1:0]    sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IW-1:0]    out_idx,
    output logic             out_last
);

    logic [N-1:0][WIDTH-1:0] ch_data;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           lock_idx;
    state_t                  state, state_nxt;
    logic                    rr_vld, gnt_vld, can_load, accept;
    logic [IW-1:0]           rr_idx, gnt_idx;

    assign ch_data = in_data;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_vld),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (state == LOCK) begin
            gnt_idx = lock_idx;
            gnt_vld = in_valid[lock_idx];
        end else if (sel_mode) begin
            gnt_idx = sel;
            if (int'(sel) < N) gnt_vld = in_valid[sel];
        end else begin
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end
    end

    assign can_load = !out_valid || out_ready;
    assign accept   = rstn && can_load && gnt_vld;

    always_comb begin
        in_ready = '0;
        if (accept) in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            ptr       <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[gnt_idx];
                out_idx   <= gnt_idx;
                out_last  <= in_last[gnt_idx];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Forced selection leaves the round-robin position alone.
            if (accept && !sel_mode)
                ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

`ifdef ARB_MUX_LOCK_EN
    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (state == IDLE && !in_last[gnt_idx])     state_nxt = LOCK;
            else if (state == LOCK && in_last[gnt_idx]) state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            lock_idx <= '0;
        else if (accept && state == IDLE && !in_last[gnt_idx])
            lock_idx <= gnt_idx;
    end
`else
    always_comb begin
        state_nxt = state;
        state_nxt = IDLE;
    end

    assign lock_idx = '0;
`endif

endmodule
